traffic_junction_ctrl: RTL

Sequences the two traffic-light heads of a main-road / side-road junction (north-south main, east-west side) plus a pedestrian crossing. It owns the single phase FSM and phase timer. It drives both 3-bit light heads with the team's one-hot light codes. It guarantees that conflicting heads are never non-red at the same time. It sits above the per-head light outputs and below the board-level sensor and button inputs.

---
 rtl/traffic_pkg.sv | 42 ++++
 rtl/phase_timer.sv | 28 ++
 rtl/traffic_junction_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the junction controller: light codes, the one-hot
// phase encoding and the phase-duration lookup used to load the phase timer.
package traffic_pkg;

  // One-hot light head codes (bit 2 = red, bit 1 = yellow, bit 0 = green)
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // One-hot phase encoding, one bit per phase
  typedef enum logic [6:0] {
    ST_ALLRED_NS = 7'b000_0001,
    ST_NS_GREEN  = 7'b000_0010,
    ST_NS_YELLOW = 7'b000_0100,
    ST_ALLRED_EW = 7'b000_1000,
    ST_WALK      = 7'b001_0000,
    ST_EW_GREEN  = 7'b010_0000,
    ST_EW_YELLOW = 7'b100_0000
  } state_t;

  // Value the phase timer loads on entry to a phase: its length minus one.
  // Anything that is not a green, yellow or walk phase is treated as all-red.
  function automatic int unsigned phase_last(
    input state_t      st,
    input int unsigned green_cycles,
    input int unsigned yellow_cycles,
    input int unsigned allred_cycles,
    input int unsigned walk_cycles
  );
    int unsigned len;
    case (st)
      ST_NS_GREEN,
      ST_EW_GREEN:  len = green_cycles;
      ST_NS_YELLOW,
      ST_EW_YELLOW: len = yellow_cycles;
      ST_WALK:      len = walk_cycles;
      default:      len = allred_cycles;
    endcase
    return len - 32'd1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for the phase timer. It stops at zero and stays
// there until the next load, which is what lets the main road rest on green.
// It has no reset of its own: the controller asserts load while in reset.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_count;

  // Load on phase entry, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (load) begin
      r_count <= load_val;
    end else if (r_count != {W{1'b0}}) begin
      r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign zero = (r_count == {W{1'b0}});

endmodule

// File: rtl/traffic_junction_ctrl.sv
// Junction controller: main road north-south, side road east-west, plus a
// pedestrian crossing served from the east-west all-red phase. Outputs are
// a pure decode of the phase register, so the two heads can never both show
// a non-red aspect in the same cycle.
module traffic_junction_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_ew,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack
);

  state_t           r_state;
  state_t           w_next;
  logic             r_ped_pending;
  logic             r_ped_ack;
  logic             w_expired;
  logic             w_enter_walk;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_reset_val;
  logic [CNT_W-1:0] w_next_val;

  assign w_reset_val = CNT_W'(phase_last(ST_ALLRED_NS, GREEN_CYCLES, YELLOW_CYCLES,
                                         ALLRED_CYCLES, WALK_CYCLES));
  assign w_next_val  = CNT_W'(phase_last(w_next, GREEN_CYCLES, YELLOW_CYCLES,
                                         ALLRED_CYCLES, WALK_CYCLES));

  // The timer reloads on every phase change, and during reset with the
  // all-red length, so each phase lasts exactly its programmed length.
  assign w_load       = reset || (w_next != r_state);
  assign w_load_val   = reset ? w_reset_val : w_next_val;
  assign w_enter_walk = (w_next == ST_WALK) && (r_state != ST_WALK);

  phase_timer #(
    .W (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_expired)
  );

  // Phase register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ALLRED_NS;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-phase decision, taken only when the current phase has expired
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ALLRED_NS: begin
        if (w_expired) w_next = ST_NS_GREEN;
        else           w_next = r_state;
      end
      ST_NS_GREEN: begin
        if (w_expired && (sensor_ew || r_ped_pending)) w_next = ST_NS_YELLOW;
        else                                          w_next = r_state;
      end
      ST_NS_YELLOW: begin
        if (w_expired) w_next = ST_ALLRED_EW;
        else           w_next = r_state;
      end
      ST_ALLRED_EW: begin
        if (w_expired && r_ped_pending) w_next = ST_WALK;
        else if (w_expired)             w_next = ST_EW_GREEN;
        else                            w_next = r_state;
      end
      ST_WALK: begin
        if (w_expired && sensor_ew) w_next = ST_EW_GREEN;
        else if (w_expired)         w_next = ST_ALLRED_NS;
        else                        w_next = r_state;
      end
      ST_EW_GREEN: begin
        if (w_expired) w_next = ST_EW_YELLOW;
        else           w_next = r_state;
      end
      ST_EW_YELLOW: begin
        if (w_expired) w_next = ST_ALLRED_NS;
        else           w_next = r_state;
      end
      default: w_next = ST_ALLRED_NS;
    endcase
  end

  // Pedestrian request latch; a press during WALK or on the entry edge is
  // already being served and is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped_pending <= 1'b0;
    end else if (w_enter_walk) begin
      r_ped_pending <= 1'b0;
    end else if (ped_req && (r_state != ST_WALK)) begin
      r_ped_pending <= 1'b1;
    end else begin
      r_ped_pending <= r_ped_pending;
    end
  end

  // Acknowledge flag, high for the first WALK cycle only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped_ack <= 1'b0;
    end else begin
      r_ped_ack <= w_enter_walk;
    end
  end

  assign ped_ack = r_ped_ack;

  // Light decode from the phase register; unknown encodings show all-red
  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    walk     = 1'b0;
    case (r_state)
      ST_NS_GREEN: begin
        ns_light = LIGHT_GREEN;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
      end
      ST_NS_YELLOW: begin
        ns_light = LIGHT_YELLOW;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
      end
      ST_WALK: begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = 1'b1;
      end
      ST_EW_GREEN: begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_GREEN;
        walk     = 1'b0;
      end
      ST_EW_YELLOW: begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_YELLOW;
        walk     = 1'b0;
      end
      default: begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
      end
    endcase
  end

endmodule
